wb_arb_4: RTL and testbench

WB_ARB_4 -- requirements
Module: wb_arb_4

---
 rtl/wb_arb_4.sv | 216 +++++++++++++++++++++
 tb/tb_wb_arb_4.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb_4.sv
// Four-master round-robin Wishbone arbiter onto a single slave.
// Optional bus watchdog compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_arb_4 #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  input  logic                    wbm0_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  input  logic                    wbm0_cyc_i,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  output logic                    wbm0_rty_o,

  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  input  logic                    wbm1_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  input  logic                    wbm1_cyc_i,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  output logic                    wbm1_rty_o,

  input  logic [ADDR_WIDTH-1:0]   wbm2_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm2_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm2_dat_o,
  input  logic                    wbm2_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm2_sel_i,
  input  logic                    wbm2_stb_i,
  input  logic                    wbm2_cyc_i,
  output logic                    wbm2_ack_o,
  output logic                    wbm2_err_o,
  output logic                    wbm2_rty_o,

  input  logic [ADDR_WIDTH-1:0]   wbm3_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm3_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm3_dat_o,
  input  logic                    wbm3_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm3_sel_i,
  input  logic                    wbm3_stb_i,
  input  logic                    wbm3_cyc_i,
  output logic                    wbm3_ack_o,
  output logic                    wbm3_err_o,
  output logic                    wbm3_rty_o,

  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arb_4: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t state, state_next;
  logic [1:0] grant, grant_next;
  logic [1:0] last_grant, last_grant_next;

  logic [ADDR_WIDTH-1:0]   adr [4];
  logic [DATA_WIDTH-1:0]   dat [4];
  logic [SELECT_WIDTH-1:0] sel [4];
  logic [3:0]              we, stb, cyc;
  logic [3:0]              ack_vec, err_vec, rty_vec;
  logic [1:0]              rr_pick;
  logic                    timeout;

  assign adr[0] = wbm0_adr_i;
  assign adr[1] = wbm1_adr_i;
  assign adr[2] = wbm2_adr_i;
  assign adr[3] = wbm3_adr_i;
  assign dat[0] = wbm0_dat_i;
  assign dat[1] = wbm1_dat_i;
  assign dat[2] = wbm2_dat_i;
  assign dat[3] = wbm3_dat_i;
  assign sel[0] = wbm0_sel_i;
  assign sel[1] = wbm1_sel_i;
  assign sel[2] = wbm2_sel_i;
  assign sel[3] = wbm3_sel_i;
  assign we     = {wbm3_we_i,  wbm2_we_i,  wbm1_we_i,  wbm0_we_i};
  assign stb    = {wbm3_stb_i, wbm2_stb_i, wbm1_stb_i, wbm0_stb_i};
  assign cyc    = {wbm3_cyc_i, wbm2_cyc_i, wbm1_cyc_i, wbm0_cyc_i};

  // Search starts one past the previous owner so every master gets a turn.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found   = 1'b0;
    rr_pick = last_grant;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && cyc[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    unique case (state)
      IDLE: begin
        if (|cyc) begin
          grant_next = rr_pick;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!cyc[grant]) begin
          last_grant_next = grant;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wd_count;
  logic        slave_term;

  assign slave_term = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // A slave termination arriving on the limit cycle takes precedence over the watchdog.
  assign timeout = (state == GRANT) && stb[grant] && !slave_term &&
                   (wd_count == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_count <= '0;
    end else if (state != GRANT || !stb[grant] || slave_term || timeout) begin
      wd_count <= '0;
    end else begin
      wd_count <= wd_count + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    ack_vec   = '0;
    err_vec   = '0;
    rty_vec   = '0;
    if (state == GRANT) begin
      wbs_adr_o      = adr[grant];
      wbs_dat_o      = dat[grant];
      wbs_sel_o      = sel[grant];
      wbs_we_o       = we[grant];
      wbs_stb_o      = stb[grant] & ~timeout;
      wbs_cyc_o      = cyc[grant];
      ack_vec[grant] = wbs_ack_i;
      err_vec[grant] = wbs_err_i | timeout;
      rty_vec[grant] = wbs_rty_i;
    end
  end

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign wbm2_dat_o = wbs_dat_i;
  assign wbm3_dat_o = wbs_dat_i;

  assign wbm0_ack_o = ack_vec[0];
  assign wbm1_ack_o = ack_vec[1];
  assign wbm2_ack_o = ack_vec[2];
  assign wbm3_ack_o = ack_vec[3];
  assign wbm0_err_o = err_vec[0];
  assign wbm1_err_o = err_vec[1];
  assign wbm2_err_o = err_vec[2];
  assign wbm3_err_o = err_vec[3];
  assign wbm0_rty_o = rty_vec[0];
  assign wbm1_rty_o = rty_vec[1];
  assign wbm2_rty_o = rty_vec[2];
  assign wbm3_rty_o = rty_vec[3];

endmodule

// File: tb/tb_wb_arb_4.sv
// Directed self-checking bench for wb_arb_4; watchdog cases run when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arb_4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_adr [4];
  logic [31:0] m_dat [4];
  logic [3:0]  m_sel [4];
  logic [3:0]  m_we, m_stb, m_cyc;
  logic [31:0] s_dat_i;
  logic        s_ack, s_err, s_rty;

  wire  [31:0] m_dat_o [4];
  wire  [3:0]  ack_o, err_o, rty_o;
  wire  [31:0] s_adr_o, s_dat_o;
  wire  [3:0]  s_sel_o;
  wire         s_we_o, s_stb_o, s_cyc_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arb_4 #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .SELECT_WIDTH  (4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_dat_o(m_dat_o[0]),
    .wbm0_we_i (m_we[0]),  .wbm0_sel_i(m_sel[0]), .wbm0_stb_i(m_stb[0]),
    .wbm0_cyc_i(m_cyc[0]), .wbm0_ack_o(ack_o[0]), .wbm0_err_o(err_o[0]), .wbm0_rty_o(rty_o[0]),
    .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_dat_o(m_dat_o[1]),
    .wbm1_we_i (m_we[1]),  .wbm1_sel_i(m_sel[1]), .wbm1_stb_i(m_stb[1]),
    .wbm1_cyc_i(m_cyc[1]), .wbm1_ack_o(ack_o[1]), .wbm1_err_o(err_o[1]), .wbm1_rty_o(rty_o[1]),
    .wbm2_adr_i(m_adr[2]), .wbm2_dat_i(m_dat[2]), .wbm2_dat_o(m_dat_o[2]),
    .wbm2_we_i (m_we[2]),  .wbm2_sel_i(m_sel[2]), .wbm2_stb_i(m_stb[2]),
    .wbm2_cyc_i(m_cyc[2]), .wbm2_ack_o(ack_o[2]), .wbm2_err_o(err_o[2]), .wbm2_rty_o(rty_o[2]),
    .wbm3_adr_i(m_adr[3]), .wbm3_dat_i(m_dat[3]), .wbm3_dat_o(m_dat_o[3]),
    .wbm3_we_i (m_we[3]),  .wbm3_sel_i(m_sel[3]), .wbm3_stb_i(m_stb[3]),
    .wbm3_cyc_i(m_cyc[3]), .wbm3_ack_o(ack_o[3]), .wbm3_err_o(err_o[3]), .wbm3_rty_o(rty_o[3]),
    .wbs_adr_o (s_adr_o),
    .wbs_dat_i (s_dat_i),
    .wbs_dat_o (s_dat_o),
    .wbs_we_o  (s_we_o),
    .wbs_sel_o (s_sel_o),
    .wbs_stb_o (s_stb_o),
    .wbs_ack_i (s_ack),
    .wbs_err_i (s_err),
    .wbs_rty_i (s_rty),
    .wbs_cyc_o (s_cyc_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; settle lets combinational outputs update.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input int m, input logic on);
    m_cyc[m] = on;
    m_stb[m] = on;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    m_we = '0; m_stb = '0; m_cyc = '0;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_adr[i] = 32'hA000_0000 | (32'(i) << 4);
      m_dat[i] = 32'h5500_0000 | 32'(i);
      m_sel[i] = 4'hF;
    end

    // Reset state: everything quiet even with a slave ack and a request present.
    settle();
    m_cyc[1] = 1'b1; s_ack = 1'b1;
    settle();
    check("rst_cyc", 64'(s_cyc_o), 64'd0);
    check("rst_acks", 64'(ack_o), 64'd0);
    m_cyc[1] = 1'b0; s_ack = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Master 2 alone reads.
    req(2, 1'b1);
    settle();
    check("m2_idle_cyc", 64'(s_cyc_o), 64'd0);
    step();
    check("m2_grant_cyc", 64'(s_cyc_o), 64'd1);
    check("m2_grant_adr", 64'(s_adr_o), 64'hA000_0020);
    check("m2_grant_we", 64'(s_we_o), 64'd0);
    s_ack = 1'b1; s_dat_i = 32'hCAFE_0002;
    req(2, 1'b0);  // drop cyc together with the ack
    settle();
    check("m2_ack_vec", 64'(ack_o), 64'b0100);
    check("m2_dat", 64'(m_dat_o[2]), 64'hCAFE_0002);
    check("m0_dat_bcast", 64'(m_dat_o[0]), 64'hCAFE_0002);
    step();
    s_ack = 1'b0;
    settle();
    check("m2_back_idle", 64'(s_cyc_o), 64'd0);

    // All four masters contend: expected order 0,1,2,3,0.
    do_reset();
    for (int m = 0; m < 4; m++) req(m, 1'b1);
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        step();
        check($sformatf("rr%0d_adr", k), 64'(s_adr_o), 64'(32'hA000_0000 | (32'(order[k]) << 4)));
        check($sformatf("rr%0d_cyc", k), 64'(s_cyc_o), 64'd1);
        s_ack = 1'b1;
        req(order[k], 1'b0);
        settle();
        check($sformatf("rr%0d_ack", k), 64'(ack_o), 64'(4'b0001 << order[k]));
        step();
        s_ack = 1'b0;
        settle();
        check($sformatf("rr%0d_gap", k), 64'(s_cyc_o), 64'd0);
        req(order[k], 1'b1);
      end
    end
    m_cyc = '0; m_stb = '0;

    // Master 1 burst of 4 acks while master 0 waits.
    do_reset();
    req(1, 1'b1);
    step();
    req(0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1;
      settle();
      check($sformatf("burst%0d_adr", b), 64'(s_adr_o), 64'hA000_0010);
      check($sformatf("burst%0d_ack", b), 64'(ack_o), 64'b0010);
      step();
    end
    s_ack = 1'b0;
    req(1, 1'b0);
    settle();
    check("burst_release_cyc", 64'(s_cyc_o), 64'd0);
    step();
    check("burst_idle_cyc", 64'(s_cyc_o), 64'd0);
    step();
    check("burst_m0_adr", 64'(s_adr_o), 64'hA000_0000);
    check("burst_m0_cyc", 64'(s_cyc_o), 64'd1);
    req(0, 1'b0);
    step();

    // Reset asserted mid-transfer.
    do_reset();
    req(3, 1'b1);
    step();
    check("abort_pre_adr", 64'(s_adr_o), 64'hA000_0030);
    for (int m = 0; m < 3; m++) req(m, 1'b1);
    s_ack = 1'b1;
    rst = 1'b1;
    settle();
    check("abort_cyc", 64'(s_cyc_o), 64'd0);
    check("abort_stb", 64'(s_stb_o), 64'd0);
    check("abort_acks", 64'(ack_o), 64'd0);
    s_ack = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("abort_next_adr", 64'(s_adr_o), 64'hA000_0000);
    m_cyc = '0; m_stb = '0;
    step();

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never responds: err on the 5th strobe cycle only.
    do_reset();
    req(1, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("wd%0d_err", c), 64'(err_o), (c == 5) ? 64'b0010 : 64'd0);
      check($sformatf("wd%0d_stb", c), 64'(s_stb_o), (c == 5) ? 64'd0 : 64'd1);
    end
    step();
    req(1, 1'b0);
    settle();
    check("wd_after_err", 64'(err_o), 64'd0);
    step();
    check("wd_idle_cyc", 64'(s_cyc_o), 64'd0);

    // Ack on the 5th strobe cycle beats the watchdog.
    req(1, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 5) begin
        s_ack = 1'b1;
        req(1, 1'b0);
      end
      settle();
      check($sformatf("wdack%0d_err", c), 64'(err_o), 64'd0);
      check($sformatf("wdack%0d_ack", c), 64'(ack_o), (c == 5) ? 64'b0010 : 64'd0);
    end
    step();
    s_ack = 1'b0;
    settle();
    check("wdack_idle_cyc", 64'(s_cyc_o), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
